// File: rtl/piso_tx_amisha_pkg.sv
// piso_tx_amisha_pkg: state encoding and serial line conventions shared by the tx/rx pair
package piso_tx_amisha_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;
  localparam logic SERIAL_IDLE = 1'b0;
  localparam bit LSB_FIRST = 1'b1;
endpackage

// File: rtl/piso_tx_amisha.sv
// piso_tx_amisha: valid/ready word in, LSB-first serial out with frame/last/busy strobes and optional idle gap
module piso_tx_amisha
  import piso_tx_amisha_pkg::*;
#(
  parameter int N_amisha = 8,
  parameter int GAP_amisha = 1
) (
  input  logic                clk_amisha,
  input  logic                reset_amisha,
  input  logic [N_amisha-1:0] d_in_amisha,
  input  logic                d_valid_amisha,
  output logic                d_ready_amisha,
  output logic                s_out_amisha,
  output logic                frame_amisha,
  output logic                last_amisha,
  output logic                busy_amisha
);
  localparam int CW = $clog2(N_amisha);
  state_t state;
  logic [N_amisha-1:0] sr;
  logic [N_amisha-1:0] d_ord;
  logic [CW-1:0] cnt;
  logic last_bit;
  logic take;
  logic gap_done;
  for (genvar b = 0; b < N_amisha; b++) begin : g_ord
    assign d_ord[b] = d_in_amisha[LSB_FIRST ? b : N_amisha-1-b];
  end
  assign s_out_amisha = sr[0];
  assign last_bit = state == SHIFT && cnt == '0;
  assign d_ready_amisha = !reset_amisha && (state == IDLE || (GAP_amisha == 0 && last_bit));
  assign take = d_valid_amisha && d_ready_amisha;
  if (GAP_amisha > 0) begin : g_gap
    localparam int GW = $clog2(GAP_amisha + 1);
    logic [GW-1:0] gcnt;
    always_ff @(posedge clk_amisha) begin
      if (reset_amisha) gcnt <= '0;
      else if (last_bit) gcnt <= GW'(GAP_amisha - 1);
      else if (gcnt != '0) gcnt <= gcnt - 1'b1;
    end
    assign gap_done = gcnt == '0;
  end else begin : g_nogap
    assign gap_done = 1'b1;
  end
  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      frame_amisha <= 1'b0;
      last_amisha <= 1'b0;
      busy_amisha <= 1'b0;
    end else if (take) begin
      state <= SHIFT;
      sr <= d_ord;
      cnt <= CW'(N_amisha - 1);
      frame_amisha <= 1'b1;
      last_amisha <= 1'b0;
      busy_amisha <= 1'b1;
    end else begin
      case (state)
        IDLE: ;
        SHIFT: begin
          sr <= {SERIAL_IDLE, sr[N_amisha-1:1]};
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            last_amisha <= cnt == CW'(1);
          end else begin
            frame_amisha <= 1'b0;
            last_amisha <= 1'b0;
            busy_amisha <= GAP_amisha > 0;
            if (GAP_amisha > 0) state <= GAP;
            else state <= IDLE;
          end
        end
        GAP: if (gap_done) begin
          state <= IDLE;
          busy_amisha <= 1'b0;
        end
        default: begin
          state <= IDLE;
          sr <= '0;
          cnt <= '0;
          frame_amisha <= 1'b0;
          last_amisha <= 1'b0;
          busy_amisha <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_piso_tx_amisha.sv
// tb_piso_tx_amisha: four configurations checked every cycle against a time-window model of the serialiser
module tb_piso_tx_amisha;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic rst [4];
  logic vld [4];
  logic [7:0] din [4];
  logic rdy [4];
  logic so [4];
  logic fr [4];
  logic la [4];
  logic bz [4];
  int cyc = 0;
  int t_acc [4];
  int rf [4];
  bit act [4];
  logic [7:0] w [4];
  logic [7:0] lb [4];
  logic [4:0] h [4][4096];
  logic [7:0] lbh [4][4096];
  piso_tx_amisha #(.N_amisha(8), .GAP_amisha(1)) u0 (.clk_amisha(clk), .reset_amisha(rst[0]), .d_in_amisha(din[0]), .d_valid_amisha(vld[0]), .d_ready_amisha(rdy[0]), .s_out_amisha(so[0]), .frame_amisha(fr[0]), .last_amisha(la[0]), .busy_amisha(bz[0]));
  piso_tx_amisha #(.N_amisha(8), .GAP_amisha(0)) u1 (.clk_amisha(clk), .reset_amisha(rst[1]), .d_in_amisha(din[1]), .d_valid_amisha(vld[1]), .d_ready_amisha(rdy[1]), .s_out_amisha(so[1]), .frame_amisha(fr[1]), .last_amisha(la[1]), .busy_amisha(bz[1]));
  piso_tx_amisha #(.N_amisha(8), .GAP_amisha(2)) u2 (.clk_amisha(clk), .reset_amisha(rst[2]), .d_in_amisha(din[2]), .d_valid_amisha(vld[2]), .d_ready_amisha(rdy[2]), .s_out_amisha(so[2]), .frame_amisha(fr[2]), .last_amisha(la[2]), .busy_amisha(bz[2]));
  piso_tx_amisha #(.N_amisha(2), .GAP_amisha(0)) u3 (.clk_amisha(clk), .reset_amisha(rst[3]), .d_in_amisha(din[3][1:0]), .d_valid_amisha(vld[3]), .d_ready_amisha(rdy[3]), .s_out_amisha(so[3]), .frame_amisha(fr[3]), .last_amisha(la[3]), .busy_amisha(bz[3]));
  function automatic int nn(int i);
    return i == 3 ? 2 : 8;
  endfunction
  function automatic int gg(int i);
    return i == 0 ? 1 : i == 2 ? 2 : 0;
  endfunction
  function automatic logic [31:0] win(int i, int t0, int len, int f);
    logic [31:0] v;
    v = '0;
    for (int j = 0; j < len; j++) v[j] = h[i][t0+j][f];
    return v;
  endfunction
  task automatic chk(string nm, int i, logic a, logic e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got=%b want=%b", nm, i, cyc, a, e);
    end
  endtask
  task automatic lit(string nm, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(int i, logic [7:0] v);
    int n;
    n = 0;
    vld[i] = 1'b1;
    din[i] = v;
    @(negedge clk);
    while (!rdy[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL handshake inst=%0d ready got=0 want=1 within 50 cycles", i);
    end
    tick();
  endtask
  task automatic rnd(int i);
    int r;
    repeat (60) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        rst[i] = 1'b1;
        vld[i] = 1'b0;
        tick();
        rst[i] = 1'b0;
      end else if (r < 3) begin
        vld[i] = 1'b0;
        repeat ($urandom_range(1, 5)) tick();
      end else send(i, 8'($urandom));
    end
    vld[i] = 1'b0;
  endtask
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      int k, n, g;
      logic es, ef, el, eb, er;
      logic [7:0] got, want;
      n = nn(i);
      g = gg(i);
      k = cyc - t_acc[i];
      ef = act[i] && k >= 1 && k <= n;
      es = ef && w[i][(k-1) & 7];
      el = act[i] && k == n;
      eb = act[i] && k >= 1 && k <= n + g;
      er = !rst[i] && cyc >= rf[i];
      chk("s_out", i, so[i], es);
      chk("frame", i, fr[i], ef);
      chk("last", i, la[i], el);
      chk("busy", i, bz[i], eb);
      chk("ready", i, rdy[i], er);
      lb[i] = rst[i] ? 8'h00 : {so[i], lb[i][7:1]};
      if (el && !rst[i]) begin
        got = lb[i] >> (8 - n);
        want = w[i] & 8'((1 << n) - 1);
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL loopback inst=%0d cyc=%0d got=%h want=%h", i, cyc, got, want);
        end
      end
      if (cyc < 4096) begin
        h[i][cyc] = {er, eb, el, ef, es};
        lbh[i][cyc] = lb[i];
      end
      if (rst[i]) begin
        act[i] = 1'b0;
        rf[i] = cyc + 1;
      end else if (vld[i] && er) begin
        act[i] = 1'b1;
        t_acc[i] = cyc;
        w[i] = din[i];
        rf[i] = g > 0 ? cyc + n + g + 1 : cyc + n;
      end
    end
    cyc++;
  end
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int t, t2;
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1;
      vld[i] = 1'b0;
      din[i] = 8'h00;
      act[i] = 1'b0;
      t_acc[i] = 0;
      rf[i] = 0;
      w[i] = 8'h00;
      lb[i] = 8'h00;
    end
    tick();
    tick();
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    send(0, 8'hA5);
    t = t_acc[0];
    vld[0] = 1'b0;
    repeat (12) tick();
    lit("t1_sout", win(0, t + 1, 8, 0), 32'hA5);
    lit("t1_frame", win(0, t + 1, 10, 1), 32'h0FF);
    lit("t1_last", win(0, t + 1, 10, 2), 32'h080);
    lit("t1_ready", win(0, t + 9, 2, 4), 32'h2);
    send(1, 8'h01);
    t = t_acc[1];
    send(1, 8'h80);
    t2 = t_acc[1];
    vld[1] = 1'b0;
    repeat (20) tick();
    lit("t2_nobubble", 32'(t2 - t), 32'd8);
    lit("t2_sout", win(1, t + 1, 16, 0), 32'h8001);
    lit("t2_frame", win(1, t + 1, 16, 1), 32'hFFFF);
    lit("t2_last", win(1, t + 1, 16, 2), 32'h8080);
    lit("t2_ready_last", win(1, t + 8, 1, 4), 32'h1);
    send(2, 8'h96);
    t = t_acc[2];
    send(2, 8'h3C);
    t2 = t_acc[2];
    vld[2] = 1'b0;
    repeat (15) tick();
    lit("t3_accept", 32'(t2 - t), 32'd11);
    lit("t3_ready", win(2, t + 1, 11, 4), 32'h400);
    lit("t3_gap_busy", win(2, t + 9, 2, 3), 32'h3);
    lit("t3_gap_frame", win(2, t + 9, 2, 1), 32'h0);
    lit("t3_sout", win(2, t2 + 1, 8, 0), 32'h3C);
    send(0, 8'hFF);
    t = t_acc[0];
    vld[0] = 1'b0;
    tick();
    tick();
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    send(0, 8'h5A);
    t2 = t_acc[0];
    vld[0] = 1'b0;
    repeat (12) tick();
    lit("t4_sout", win(0, t + 1, 4, 0), 32'h7);
    lit("t4_frame", win(0, t + 1, 4, 1), 32'h7);
    lit("t4_busy", win(0, t + 4, 1, 3), 32'h0);
    lit("t4_ready", win(0, t + 3, 2, 4), 32'h2);
    lit("t4_next", win(0, t2 + 1, 8, 0), 32'h5A);
    send(0, 8'hC3);
    t = t_acc[0];
    vld[0] = 1'b0;
    repeat (12) tick();
    lit("t5_loopback", 32'(lbh[0][t + 8]), 32'hC3);
    send(3, 8'h02);
    t = t_acc[3];
    send(3, 8'h01);
    vld[3] = 1'b0;
    repeat (8) tick();
    lit("t6_sout", win(3, t + 1, 4, 0), 32'h6);
    lit("t6_last", win(3, t + 1, 4, 2), 32'hA);
    fork
      rnd(0);
      rnd(1);
      rnd(2);
      rnd(3);
    join
    repeat (15) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
